// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: default datapath geometry and
// the sequencing states of the iterative adder.
package alu_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int ALU_DIGIT = 8;
    localparam int ALU_NDIG  = ALU_WIDTH / ALU_DIGIT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : alu_pkg

// File: rtl/add_digit.sv
// Combinational DIGIT-bit ripple-carry adder: one digit slice of the
// iterative adder.
module add_digit
    import alu_pkg::*;
#(
    parameter int DIGIT = ALU_DIGIT
) (
    output logic [DIGIT-1:0] s,
    output logic             cout,
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci
);

    logic c;

    // Ripple the carry bit by bit through the digit.
    always_comb begin
        // NOTE: blocking assignments here model the carry chain in order;
        // each iteration reads the carry produced by the previous bit.
        s = '0;
        c = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule : add_digit

// File: rtl/add_serial.sv
// Iterative adder: adds one DIGIT-bit digit per clock, LSB digit first, and
// publishes sum, carry-out and Y86 flags with a one-cycle done pulse.
module add_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DIGIT = ALU_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int MSB   = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cy_q, cy_d;      // running carry between digits
    logic [WIDTH-1:0]   acc_q, acc_d;    // sum under construction
    logic [WIDTH-1:0]   sum_q, sum_d;    // published sum, loaded once per op
    logic               carry_q, carry_d;
    logic               zf_q, zf_d;
    logic               sf_q, sf_d;
    logic               of_q, of_d;

    int                 dig_lsb;
    logic [DIGIT-1:0]   dig_x, dig_y, dig_s;
    logic               dig_co;

    // Select the current operand digit by the counter.
    assign dig_lsb = int'(cnt_q) * DIGIT;
    assign dig_x   = a_q[dig_lsb +: DIGIT];
    assign dig_y   = b_q[dig_lsb +: DIGIT];

    add_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .s    (dig_s),
        .cout (dig_co),
        .x    (dig_x),
        .y    (dig_y),
        .ci   (cy_q)
    );

    // Next-state and datapath update for IDLE -> RUN -> DONE sequencing.
    always_comb begin
        // NOTE: every target gets its hold value first so no path through
        // the case statement leaves a variable unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cy_d    = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[dig_lsb +: DIGIT] = dig_s;
                cy_d  = dig_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    sum_d   = acc_d;
                    carry_d = dig_co;
                    zf_d    = (acc_d == '0);
                    sf_d    = acc_d[MSB];
                    of_d    = (a_q[MSB] == b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of every other register.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;
    assign zf    = zf_q;
    assign sf    = sf_q;
    assign of    = of_q;

endmodule : add_serial

// File: tb/tb_add_serial.sv
// Self-checking bench for add_serial: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every done pulse.
module tb_add_serial;

    localparam int W    = 64;
    localparam int NDIG = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        logic         zf;
        logic         sf;
        logic         of;
        int           acc_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, carry, zf, sf, of;
    logic [W-1:0] sum;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    add_serial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry),
        .zf    (zf),
        .sf    (sf),
        .of    (of)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width addition treated as an unsigned 65-bit number.
    function automatic exp_t model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t e;
        logic [W:0] t;
        t         = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.sum     = t[W-1:0];
        e.carry   = t[W];
        e.zf      = (e.sum == '0);
        e.sf      = e.sum[W-1];
        e.of      = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Reference for the subtract path: plain difference x - y.
    function automatic exp_t model_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.sum     = x - y;
        e.carry   = (x >= y);
        e.zf      = (e.sum == '0);
        e.sf      = e.sum[W-1];
        e.of      = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            check("done_one_cycle", {63'd0, prev_done}, 64'd0);
            check("busy_in_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("carry", {63'd0, carry}, {63'd0, e.carry});
                check("zf", {63'd0, zf}, {63'd0, e.zf});
                check("sf", {63'd0, sf}, {63'd0, e.sf});
                check("of", {63'd0, of}, {63'd0, e.of});
                check("latency", 64'(cyc - e.acc_cyc), 64'(NDIG));
            end
        end
        prev_done = (done === 1'b1);
    end

    // One operation from IDLE; returns with the DUT back in IDLE.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input exp_t e);
        @(negedge clk);
        a = x; b = y; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e.acc_cyc = cyc;
        sb.push_back(e);
        a = $urandom(); b = $urandom();   // late operand changes must not matter
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        repeat (NDIG + 1) @(posedge clk);
        #1;
        check("busy_idle", {63'd0, busy}, 64'd0);
        check("sum_hold", sum, e.sum);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] x, y;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum", sum, 64'd0);
        check("rst_flags", {59'd0, carry, zf, sf, of}, 64'd0);
        rst_n = 1'b1;

        // Directed vectors.
        run_op(64'd31, 64'd63, 1'b0, model_add(64'd31, 64'd63, 1'b0));
        run_op('1, 64'd1, 1'b0, model_add('1, 64'd1, 1'b0));
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, model_add(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1));
        run_op(64'd31, ~64'd63, 1'b1, model_sub(64'd31, 64'd63));

        // Subtract sweep against the plain difference.
        for (int i = 0; i < 16; i++) begin
            x = 64'(31 - i);
            y = 64'(62 - i);
            run_op(x, ~y, 1'b1, model_sub(x, y));
        end

        // Random operands with random idle gaps.
        for (int i = 0; i < 30; i++) begin
            logic ci;
            x  = {$urandom(), $urandom()};
            y  = {$urandom(), $urandom()};
            ci = 1'($urandom_range(1));
            if (i % 5 == 0) y = ~x;            // long carry propagation
            run_op(x, y, ci, model_add(x, y, ci));
            repeat ($urandom_range(2)) @(posedge clk);
        end

        // start re-pulsed during RUN is ignored.
        @(negedge clk);
        x = 64'h0123_4567_89AB_CDEF; y = 64'hFEDC_BA98_7654_3210;
        a = x; b = y; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e = model_add(x, y, 1'b1); e.acc_cyc = cyc; sb.push_back(e);
        repeat (3) @(posedge clk); #1;
        start = 1'b1; a = '1; b = '1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (NDIG + 4) @(posedge clk);

        // start held high: back-to-back operations every NDIG+2 cycles.
        @(negedge clk);
        x = 64'hDEAD_BEEF_0000_0001; y = 64'h2152_4111_FFFF_FFFF;
        a = x; b = y; cin = 1'b0; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = model_add(x, y, 1'b0); e.acc_cyc = cyc; sb.push_back(e);
            if (k < 2) repeat (NDIG + 1) @(posedge clk);
        end
        start = 1'b0;
        repeat (NDIG + 3) @(posedge clk);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        a = 64'd1000; b = 64'd2000; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_sum", sum, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        rst_n = 1'b1;
        repeat (NDIG + 4) @(posedge clk);
        run_op(64'd5, 64'd7, 1'b1, model_add(64'd5, 64'd7, 1'b1));

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_add_serial
